// File: rtl/uart_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : uart_tx_pkg                                                      |
// | Brief   : Shared UART definitions: config, mode, TX irq flags, data width. |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package uart_tx_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    SIMPLEX     = 2'd0,
    HALF_DUPLEX = 2'd1,
    FULL_DUPLEX = 2'd2
  } mode_t;

  typedef struct packed {
    mode_t mode;
    logic  master;
    logic  flush_tx;
  } Config_t;

  typedef struct packed {
    logic done;
    logic empty;
    logic full;
  } TXIrqFlags_t;

  // Even parity bit: 1 when the byte holds an odd number of ones.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_tx_fifo                                                     |
// | Brief   : Synchronous FIFO with flush, valid/ready enqueue and dequeue.    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module uart_tx_fifo #(
  parameter int DATA_SIZE   = 8,
  parameter int BUFFER_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic [DATA_SIZE-1:0] enq_data_i,
  input  logic                 enq_valid_i,
  output logic                 enq_ready_o,
  output logic [DATA_SIZE-1:0] deq_data_o,
  output logic                 deq_valid_o,
  input  logic                 deq_ready_i,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int AW = $clog2(BUFFER_SIZE);
  localparam logic [AW:0] C_FULL_CNT = (AW+1)'(BUFFER_SIZE);

  logic [DATA_SIZE-1:0] mem_q [BUFFER_SIZE];
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        rd_ptr_q;
  logic [AW:0]          count_q;

  logic w_full;
  logic w_empty;
  logic w_enq;
  logic w_deq;

  assign w_full  = (count_q == C_FULL_CNT);
  assign w_empty = (count_q == '0);
  // A flush cycle drops any concurrent enqueue so the FIFO ends up truly empty.
  assign w_enq   = enq_valid_i & ~w_full & ~flush_i;
  assign w_deq   = deq_ready_i & ~w_empty;

  assign enq_ready_o = ~w_full;
  assign deq_valid_o = ~w_empty;
  assign deq_data_o  = mem_q[rd_ptr_q];
  assign full_o      = w_full;
  assign empty_o     = w_empty;

  // Pointer and occupancy tracking; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_enq) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_deq) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_enq, w_deq})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_enq) mem_q[wr_ptr_q] <= enq_data_i;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_tx                                                          |
// | Brief   : UART transmitter: TX FIFO, 8E1 framing, RTS/CTS flow control.   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tck_en,
  output logic                      tx,
  output logic                      tx_rts_n,
  input  logic                      tx_cts_n,
  input  logic [UART_DATA_BITS-1:0] txfifo_data,
  input  logic                      txfifo_valid,
  output logic                      txfifo_ready,
  output logic                      txfifo_full,
  output logic                      txfifo_empty,
  output logic                      busy,
  output TXIrqFlags_t               tx_irq_flags,
  input  Config_t                   uart_config
);

  localparam logic [1:0] C_IDLE   = 2'd0;
  localparam logic [1:0] C_SHIFT  = 2'd1;
  localparam logic [1:0] C_PARITY = 2'd2;
  localparam logic [1:0] C_STOP   = 2'd3;

  logic [1:0]                state_q, state_d;
  logic [2:0]                cnt_q,   cnt_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                      par_q,   par_d;
  logic                      tx_q,    tx_d;
  logic                      done_d;
  TXIrqFlags_t               irq_q;

  logic                      w_en;
  logic                      w_launch;
  logic [UART_DATA_BITS-1:0] w_fifo_data;
  logic                      w_fifo_valid;
  logic                      w_fifo_full;
  logic                      w_fifo_empty;

  // Simplex links only transmit from the master side.
  assign w_en = (uart_config.mode != SIMPLEX) | uart_config.master;

  // CTS is only looked at here; once a frame starts it runs to completion.
  assign w_launch = tck_en & w_en & w_fifo_valid & ~tx_cts_n & (state_q == C_IDLE);

  uart_tx_fifo #(
    .DATA_SIZE   (UART_DATA_BITS),
    .BUFFER_SIZE (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (uart_config.flush_tx),
    .enq_data_i  (txfifo_data),
    .enq_valid_i (txfifo_valid),
    .enq_ready_o (txfifo_ready),
    .deq_data_o  (w_fifo_data),
    .deq_valid_o (w_fifo_valid),
    .deq_ready_i (w_launch),
    .full_o      (w_fifo_full),
    .empty_o     (w_fifo_empty)
  );

  assign txfifo_full  = w_fifo_full;
  assign txfifo_empty = w_fifo_empty;
  assign tx_rts_n     = ~(w_en & ~w_fifo_empty);
  assign busy         = (state_q != C_IDLE);
  assign tx           = tx_q;
  assign tx_irq_flags = irq_q;

  // Frame sequencer: everything advances only on baud ticks.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    if (tck_en) begin
      case (state_q)
        C_IDLE: begin
          if (w_launch) begin
            shreg_d = w_fifo_data;
            par_d   = even_parity(w_fifo_data);
            cnt_d   = 3'd0;
            tx_d    = 1'b0;
            state_d = C_SHIFT;
          end else begin
            tx_d = 1'b1;
          end
        end
        C_SHIFT: begin
          tx_d    = shreg_q[0];
          shreg_d = {1'b0, shreg_q[UART_DATA_BITS-1:1]};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = C_PARITY;
        end
        C_PARITY: begin
          tx_d    = par_q;
          state_d = C_STOP;
        end
        default: begin
          tx_d    = 1'b1;
          done_d  = 1'b1;
          state_d = C_IDLE;
        end
      endcase
    end
  end

  // State registers with synchronous reset; reset forces the line idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= C_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      irq_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      tx_q        <= tx_d;
      irq_q.done  <= done_d;
      irq_q.empty <= w_fifo_empty;
      irq_q.full  <= w_fifo_full;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_uart_tx                                                       |
// | Brief   : Self-checking bench for uart_tx against a byte-queue model.      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_uart_tx;
  import uart_tx_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        tck_en;
  logic        tx;
  logic        tx_rts_n;
  logic        tx_cts_n;
  logic [7:0]  txfifo_data;
  logic        txfifo_valid;
  logic        txfifo_ready;
  logic        txfifo_full;
  logic        txfifo_empty;
  logic        busy;
  TXIrqFlags_t tx_irq_flags;
  Config_t     cfg;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  // Model: bytes the FIFO should hold, and the bit stream expected on tx.
  logic [7:0] mq [$];
  logic       eb [$];

  uart_tx #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .tck_en       (tck_en),
    .tx           (tx),
    .tx_rts_n     (tx_rts_n),
    .tx_cts_n     (tx_cts_n),
    .txfifo_data  (txfifo_data),
    .txfifo_valid (txfifo_valid),
    .txfifo_ready (txfifo_ready),
    .txfifo_full  (txfifo_full),
    .txfifo_empty (txfifo_empty),
    .busy         (busy),
    .tx_irq_flags (tx_irq_flags),
    .uart_config  (cfg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_irq_flags.done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    @(negedge clk);
    txfifo_data  = d;
    txfifo_valid = 1'b1;
    if (mq.size() < DEPTH) mq.push_back(d);
    @(negedge clk);
    txfifo_valid = 1'b0;
  endtask

  // Queue the 11 line bits of the next modelled byte: start, data LSB first, parity, stop.
  task automatic load_frame();
    logic [7:0] b;
    int ones;
    b = mq.pop_front();
    ones = 0;
    eb.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      eb.push_back(((b >> i) & 8'd1) != 8'd0);
      ones += (b >> i) & 1;
    end
    eb.push_back((ones % 2) == 1);
    eb.push_back(1'b1);
  endtask

  // One baud tick every 4 clocks; line checked right after each tick edge.
  task automatic run_ticks(input int n);
    logic e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      tck_en = 1'b1;
      @(negedge clk);
      tck_en = 1'b0;
      e = (eb.size() != 0) ? eb.pop_front() : 1'b1;
      chk("tx_bit", 32'(tx), 32'(e));
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; tck_en = 1'b0; tx_cts_n = 1'b0;
    txfifo_data = 8'h00; txfifo_valid = 1'b0;
    cfg.mode = FULL_DUPLEX; cfg.master = 1'b0; cfg.flush_tx = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_tx",    32'(tx), 1);
    chk("rst_rts_n", 32'(tx_rts_n), 1);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_empty", 32'(txfifo_empty), 1);
    chk("rst_full",  32'(txfifo_full), 0);
    chk("rst_ready", 32'(txfifo_ready), 1);
    chk("rst_irq",   32'(tx_irq_flags), 0);
    rst = 1'b0;

    // Single byte 0xA5
    push(8'hA5);
    chk("a5_rts_n", 32'(tx_rts_n), 0);
    load_frame();
    run_ticks(11);
    chk("a5_done_cnt", 32'(done_cnt), 1);
    chk("a5_busy",     32'(busy), 0);

    // Back-to-back 0x07, 0x00 with no idle gap
    push(8'h07);
    push(8'h00);
    load_frame();
    load_frame();
    run_ticks(22);
    chk("b2b_done_cnt", 32'(done_cnt), 3);

    // CTS held off: line stays idle while RTS is asserted
    tx_cts_n = 1'b1;
    push(8'($urandom));
    chk("cts_rts_n", 32'(tx_rts_n), 0);
    run_ticks(20);
    chk("cts_busy", 32'(busy), 0);
    tx_cts_n = 1'b0;
    load_frame();
    run_ticks(11);

    // Simplex slave is disabled until it becomes master
    cfg.mode = SIMPLEX; cfg.master = 1'b0;
    push(8'h55);
    chk("spx_rts_n", 32'(tx_rts_n), 1);
    chk("spx_empty", 32'(txfifo_empty), 0);
    run_ticks(3);
    cfg.master = 1'b1;
    load_frame();
    run_ticks(11);
    cfg.mode = FULL_DUPLEX; cfg.master = 1'b0;

    // Fill to full, 9th write dropped, drain in order
    tx_cts_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) push(8'($urandom));
    chk("full_flag",  32'(txfifo_full), 1);
    chk("full_ready", 32'(txfifo_ready), 0);
    @(negedge clk);
    chk("full_irq",   32'(tx_irq_flags.full), 1);
    push(8'($urandom));
    chk("full_still", 32'(txfifo_full), 1);
    tx_cts_n = 1'b0;
    for (int i = 0; i < DEPTH; i++) load_frame();
    run_ticks(11 * DEPTH);
    chk("drain_empty", 32'(txfifo_empty), 1);
    @(negedge clk);
    chk("drain_irq_empty", 32'(tx_irq_flags.empty), 1);

    // Flush mid-frame: current frame finishes, queued bytes discarded
    for (int i = 0; i < 4; i++) push(8'($urandom));
    load_frame();
    run_ticks(5);
    @(negedge clk);
    cfg.flush_tx = 1'b1;
    @(negedge clk);
    cfg.flush_tx = 1'b0;
    mq.delete();
    chk("flush_empty", 32'(txfifo_empty), 1);
    run_ticks(6);
    run_ticks(11);
    chk("flush_busy", 32'(busy), 0);

    // Reset mid-frame aborts it and idles the line
    push(8'h00);
    load_frame();
    run_ticks(4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_tx",   32'(tx), 1);
    chk("mrst_busy", 32'(busy), 0);
    rst = 1'b0;
    eb.delete();
    mq.delete();
    run_ticks(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
